// File: rtl/factor_control_pkg.sv
// Shared constants, FSM encoding and width helper for the factor_control button stage.
package factor_control_pkg;

    localparam int unsigned FACTOR_W = 5;

    // 100 MHz board timing
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int unsigned HOLD_CYCLES_DEF     = 50_000_000;
    localparam int unsigned REPEAT_CYCLES_DEF   = 10_000_000;

    // Shortened timing for simulation
    localparam int unsigned DEBOUNCE_CYCLES_SIM = 4;
    localparam int unsigned HOLD_CYCLES_SIM     = 20;
    localparam int unsigned REPEAT_CYCLES_SIM   = 5;

    localparam logic [FACTOR_W-1:0] RESET_FACTOR_DEF = 5'd0;
    localparam logic [FACTOR_W-1:0] MAX_FACTOR_DEF   = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_REPEAT  = 2'd2,
        ST_LOCKOUT = 2'd3
    } fsm_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/factor_control_button_debounce.sv
// Two-flop synchroniser followed by a stable-sample debouncer for one raw pushbutton.
module button_debounce
    import factor_control_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    // Level flips only after DEBOUNCE_CYCLES consecutive samples disagree with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign level = r_level;

endmodule

// File: rtl/factor_control.sv
// Pushbutton-driven saturating division factor with hold-to-repeat, feeding clock_manager.
module factor_control
    import factor_control_pkg::*;
#(
    parameter int unsigned          DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned          HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int unsigned          REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
    parameter logic [FACTOR_W-1:0]  RESET_FACTOR    = RESET_FACTOR_DEF,
    parameter logic [FACTOR_W-1:0]  MAX_FACTOR      = MAX_FACTOR_DEF
) (
    input  logic                factor_control_clk,
    input  logic                factor_control_rst,
    input  logic                factor_control_up,
    input  logic                factor_control_down,
    output logic [FACTOR_W-1:0] factor_control_factor,
    output logic                factor_control_changed,
    output logic                factor_control_at_limit
);

    localparam int unsigned TIMER_W =
        cnt_width((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
    localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_CYCLES - 1);
    localparam logic RESET_AT_LIMIT = (RESET_FACTOR == '0) || (RESET_FACTOR == MAX_FACTOR);

    logic                w_up_lvl;
    logic                w_dn_lvl;
    logic                r_up_d;
    logic                r_dn_d;
    logic                w_up_rise;
    logic                w_dn_rise;
    logic                w_active;
    logic                w_other;
    logic [TIMER_W-1:0]  w_last;

    fsm_state_t          r_state;
    fsm_state_t          w_state_nxt;
    logic [TIMER_W-1:0]  r_timer;
    logic [TIMER_W-1:0]  w_timer_nxt;
    logic                r_dir;
    logic                w_dir_nxt;
    logic                w_step;
    logic                w_step_up;

    logic [FACTOR_W-1:0] r_factor;
    logic [FACTOR_W-1:0] w_factor_nxt;
    logic                r_changed;
    logic                r_at_limit;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_debounce (
        .clk   (factor_control_clk),
        .rst   (factor_control_rst),
        .raw   (factor_control_up),
        .level (w_up_lvl)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn_debounce (
        .clk   (factor_control_clk),
        .rst   (factor_control_rst),
        .raw   (factor_control_down),
        .level (w_dn_lvl)
    );

    assign w_up_rise = w_up_lvl & ~r_up_d;
    assign w_dn_rise = w_dn_lvl & ~r_dn_d;
    assign w_active  = r_dir ? w_up_lvl : w_dn_lvl;
    assign w_other   = r_dir ? w_dn_lvl : w_up_lvl;
    assign w_last    = (r_state == ST_HOLD) ? HOLD_LAST : REPEAT_LAST;

    // Next state, shared timer and step request
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_dir_nxt   = r_dir;
        w_step      = 1'b0;
        w_step_up   = r_dir;
        case (r_state)
            ST_IDLE: begin
                if (w_up_rise && w_dn_rise) begin
                    w_state_nxt = ST_LOCKOUT;
                end else if (w_up_rise || w_dn_rise) begin
                    w_step      = 1'b1;
                    w_step_up   = w_up_rise;
                    w_dir_nxt   = w_up_rise;
                    w_timer_nxt = '0;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (!w_active) begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = '0;
                end else if (w_other) begin
                    w_state_nxt = ST_LOCKOUT;
                    w_timer_nxt = '0;
                end else if (r_timer == w_last) begin
                    w_step      = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = ST_REPEAT;
                end else begin
                    w_timer_nxt = r_timer + TIMER_W'(1);
                end
            end
            ST_LOCKOUT: begin
                if (!w_up_lvl && !w_dn_lvl) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // Saturating step; a step at either limit leaves the factor untouched
    always_comb begin
        w_factor_nxt = r_factor;
        if (w_step) begin
            if (w_step_up) begin
                if (r_factor < MAX_FACTOR) begin
                    w_factor_nxt = r_factor + FACTOR_W'(1);
                end
            end else if (r_factor != '0) begin
                w_factor_nxt = r_factor - FACTOR_W'(1);
            end
        end
    end

    always_ff @(posedge factor_control_clk or negedge factor_control_rst) begin
        if (!factor_control_rst) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_dir      <= 1'b0;
            r_up_d     <= 1'b0;
            r_dn_d     <= 1'b0;
            r_factor   <= RESET_FACTOR;
            r_changed  <= 1'b0;
            r_at_limit <= RESET_AT_LIMIT;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_dir      <= w_dir_nxt;
            r_up_d     <= w_up_lvl;
            r_dn_d     <= w_dn_lvl;
            r_factor   <= w_factor_nxt;
            r_changed  <= (w_factor_nxt != r_factor);
            r_at_limit <= (w_factor_nxt == '0) || (w_factor_nxt == MAX_FACTOR);
        end
    end

    assign factor_control_factor   = r_factor;
    assign factor_control_changed  = r_changed;
    assign factor_control_at_limit = r_at_limit;

endmodule
